// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the operand-memory port arbiter.
// Owner codes match the mem_sel mux encoding (1 = matrix loader).
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_ADDR_W = 4;

  localparam logic OWNER_P1 = 1'b1;
  localparam logic OWNER_P2 = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } arb_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory-path and read-return signals of the two-port arbiter.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_W = mem_port_arbiter_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = mem_port_arbiter_pkg::DEF_ADDR_W
);

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              we1;
  logic              req2;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata2;
  logic              we2;
  logic [DATA_W-1:0] mem_rdata;

  logic              gnt1;
  logic              gnt2;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] rdata;
  logic              rvalid1;
  logic              rvalid2;

  modport slave (
    input  req1, addr1, wdata1, we1,
    input  req2, addr2, wdata2, we2,
    input  mem_rdata,
    output gnt1, gnt2, mem_sel, mem_addr, mem_wdata, mem_we,
    output rdata, rvalid1, rvalid2
  );

  modport master (
    output req1, addr1, wdata1, we1,
    output req2, addr2, wdata2, we2,
    output mem_rdata,
    input  gnt1, gnt2, mem_sel, mem_addr, mem_wdata, mem_we,
    input  rdata, rvalid1, rvalid2
  );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// 4-bit 2:1 memory-path mux; sel=1 picks a1 (port 1), en=0 forces zero.
module mem_port_arbiter_mux (
  input  logic [3:0] a1,
  input  logic [3:0] a2,
  input  logic       sel,
  input  logic       en,
  output logic [3:0] y
);

  always_comb begin
    y = '0;
    if (en) y = sel ? a1 : a2;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one operand memory between the
// matrix loader (port 1) and the MAC engine (port 2), with read-return steering.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(MAX_BURST);

  arb_state_t       state;
  arb_state_t       nxt;
  logic             gnt1_q;
  logic             gnt2_q;
  logic             sel_q;
  logic             last_owner;
  logic             rv1_q;
  logic             rv2_q;
  logic [CNT_W-1:0] count;

  logic             beat1;
  logic             beat2;
  logic             beat;
  logic             burst_end;
  logic             leave;
  logic             owned;

  logic [DATA_W-1:0] wdata_mux;
  logic [ADDR_W-1:0] addr_mux;

  always_comb begin
    beat1     = gnt1_q & bus.req1;
    beat2     = gnt2_q & bus.req2;
    beat      = beat1 | beat2;
    burst_end = beat && (count == CNT_W'(MAX_BURST - 1));
    leave     = 1'b0;
    nxt       = state;
    case (state)
      IDLE: begin
        if (bus.req1 && (!bus.req2 || last_owner == OWNER_P2)) nxt = OWN1;
        else if (bus.req2)                                     nxt = OWN2;
      end
      OWN1: begin
        leave = !bus.req1 || burst_end;
        if (leave) nxt = bus.req2 ? OWN2 : (bus.req1 ? OWN1 : IDLE);
      end
      OWN2: begin
        leave = !bus.req2 || burst_end;
        if (leave) nxt = bus.req1 ? OWN1 : (bus.req2 ? OWN2 : IDLE);
      end
      default: nxt = IDLE;
    endcase
  end

  // Grants are registered copies of the next state so they rise with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt1_q     <= 1'b0;
      gnt2_q     <= 1'b0;
      sel_q      <= 1'b0;
      last_owner <= OWNER_P2;
      rv1_q      <= 1'b0;
      rv2_q      <= 1'b0;
      count      <= '0;
    end else begin
      state  <= nxt;
      gnt1_q <= (nxt == OWN1);
      gnt2_q <= (nxt == OWN2);
      sel_q  <= (nxt == OWN1);
      rv1_q  <= beat1 & ~bus.we1;
      rv2_q  <= beat2 & ~bus.we2;
      if (leave) last_owner <= (state == OWN1) ? OWNER_P1 : OWNER_P2;
      // A re-grant to the same port after an exhausted burst also restarts the count.
      if (leave || state == IDLE) count <= '0;
      else if (beat)              count <= count + CNT_W'(1);
    end
  end

  assign owned = gnt1_q | gnt2_q;

  for (genvar i = 0; i < DATA_W / 4; i++) begin : g_wdata
    mem_port_arbiter_mux u_mux (
      .a1  (bus.wdata1[4*i +: 4]),
      .a2  (bus.wdata2[4*i +: 4]),
      .sel (sel_q),
      .en  (owned),
      .y   (wdata_mux[4*i +: 4])
    );
  end

  for (genvar i = 0; i < ADDR_W / 4; i++) begin : g_addr
    mem_port_arbiter_mux u_mux (
      .a1  (bus.addr1[4*i +: 4]),
      .a2  (bus.addr2[4*i +: 4]),
      .sel (sel_q),
      .en  (owned),
      .y   (addr_mux[4*i +: 4])
    );
  end

  assign bus.gnt1      = gnt1_q;
  assign bus.gnt2      = gnt2_q;
  assign bus.mem_sel   = sel_q;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_we    = beat & (sel_q ? bus.we1 : bus.we2);
  assign bus.rdata     = bus.mem_rdata;
  assign bus.rvalid1   = rv1_q;
  assign bus.rvalid2   = rv2_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle model for grants and memory
// path, plus a queue of expected read returns popped as rvalid appears.
module tb_mem_port_arbiter;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned MB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state: owner 0 = idle, 1 / 2 = port; m_left = beats left in burst.
  int          m_owner = 0;
  int          m_left  = MB;
  int          m_last  = 2;
  bit          m_rv1   = 1'b0;
  bit          m_rv2   = 1'b0;
  logic [3:0]  tb_mem [16];
  logic [5:0]  rdq [$];
  logic [3:0]  pend_rd = '0;
  bit          pend_v  = 1'b0;
  int unsigned wr_cnt  = 0;
  int unsigned idle_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_left  = MB;
    m_last  = 2;
    m_rv1   = 1'b0;
    m_rv2   = 1'b0;
    pend_v  = 1'b0;
    rdq.delete();
  endtask

  task automatic drive_idle();
    bus.req1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.we1 = 1'b0;
    bus.req2 = 1'b0; bus.addr2 = '0; bus.wdata2 = '0; bus.we2 = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic step(input bit r1, input logic [3:0] a1, input logic [3:0] d1, input bit w1,
                      input bit r2, input logic [3:0] a2, input logic [3:0] d2, input bit w2);
    bit         g1, g2, b1, b2, ewe, rq, ro;
    logic [3:0] ea, ed;
    logic [5:0] e;
    @(negedge clk);
    bus.req1 = r1; bus.addr1 = a1; bus.wdata1 = d1; bus.we1 = w1;
    bus.req2 = r2; bus.addr2 = a2; bus.wdata2 = d2; bus.we2 = w2;
    bus.mem_rdata = pend_v ? pend_rd : 4'($urandom);
    #1;
    g1  = (m_owner == 1);
    g2  = (m_owner == 2);
    b1  = g1 && r1;
    b2  = g2 && r2;
    ea  = g1 ? a1 : (g2 ? a2 : 4'h0);
    ed  = g1 ? d1 : (g2 ? d2 : 4'h0);
    ewe = (b1 && w1) || (b2 && w2);
    check("gnt1", bus.gnt1, g1);
    check("gnt2", bus.gnt2, g2);
    check("mem_sel", bus.mem_sel, g1);
    check("gnt_excl", bus.gnt1 & bus.gnt2, 1'b0);
    check("mem_we", bus.mem_we, ewe);
    check("mem_addr", bus.mem_addr, ea);
    check("mem_wdata", bus.mem_wdata, ed);
    check("rvalid1", bus.rvalid1, m_rv1);
    check("rvalid2", bus.rvalid2, m_rv2);
    if (bus.rvalid1 || bus.rvalid2) begin
      check("rd_pending", rdq.size() != 0, 1'b1);
      if (rdq.size() != 0) begin
        e = rdq.pop_front();
        check("rd_port", {bus.rvalid1, bus.rvalid2}, e[5:4]);
        check("rd_data", bus.rdata, e[3:0]);
      end
    end
    if (bus.mem_we && bus.mem_addr == 4'h3 && bus.mem_wdata == 4'hA) wr_cnt++;
    if (!bus.gnt1 && !bus.gnt2) idle_cnt++;

    // Advance the model across the coming rising edge.
    pend_v = 1'b0;
    m_rv1  = b1 && !w1;
    m_rv2  = b2 && !w2;
    if (m_rv1) begin rdq.push_back({2'b10, tb_mem[a1]}); pend_rd = tb_mem[a1]; pend_v = 1'b1; end
    if (m_rv2) begin rdq.push_back({2'b01, tb_mem[a2]}); pend_rd = tb_mem[a2]; pend_v = 1'b1; end
    if (b1 && w1) tb_mem[a1] = d1;
    if (b2 && w2) tb_mem[a2] = d2;
    if (m_owner == 0) begin
      if (r1 && (!r2 || m_last == 2)) m_owner = 1;
      else if (r2)                    m_owner = 2;
      m_left = MB;
    end else begin
      rq = (m_owner == 1) ? r1 : r2;
      ro = (m_owner == 1) ? r2 : r1;
      if (b1 || b2) m_left--;
      if (!rq || m_left == 0) begin
        m_last  = m_owner;
        m_owner = ro ? (3 - m_owner) : (rq ? m_owner : 0);
        m_left  = MB;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    #1;
    check("rst_gnt1", bus.gnt1, 1'b0);
    check("rst_gnt2", bus.gnt2, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_rvalid1", bus.rvalid1, 1'b0);
    check("rst_rvalid2", bus.rvalid2, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 4'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tb_mem[i] = 4'(i) ^ 4'h9;
    tb_mem[5] = 4'h7;
    drive_idle();

    // Reset then idle.
    do_reset();
    repeat (3) step(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);

    // Single requester burst with forced rotation back to itself.
    wr_cnt = 0;
    repeat (7) step(1, 4'h3, 4'hA, 1, 0, 4'h0, 4'h0, 0);
    repeat (2) step(0, 4'h3, 4'hA, 1, 0, 4'h0, 4'h0, 0);
    check("burst_writes", wr_cnt, 6);

    // Contention round-robin with reads on both sides.
    do_reset();
    step(1, 4'h1, 4'h0, 0, 1, 4'h5, 4'h0, 0);
    idle_cnt = 0;
    repeat (12) step(1, 4'h1, 4'h0, 0, 1, 4'h5, 4'h0, 0);
    check("handover_idle", idle_cnt, 0);
    repeat (2) step(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);

    // Read return steering to port 2.
    do_reset();
    step(0, 4'h0, 4'h0, 0, 1, 4'h5, 4'h0, 0);
    step(0, 4'h0, 4'h0, 0, 1, 4'h5, 4'h0, 0);
    step(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
    check("steer_rdata", bus.rdata, 4'h7);
    check("steer_rvalid2", bus.rvalid2, 1'b1);
    check("steer_rvalid1", bus.rvalid1, 1'b0);
    step(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);

    // Early release by port 1 while port 2 waits.
    do_reset();
    step(1, 4'h2, 4'hB, 1, 0, 4'h6, 4'hC, 1);
    step(1, 4'h2, 4'hB, 1, 0, 4'h6, 4'hC, 1);
    step(1, 4'h2, 4'hB, 1, 1, 4'h6, 4'hC, 1);
    step(0, 4'h2, 4'hB, 1, 1, 4'h6, 4'hC, 1);
    repeat (3) step(0, 4'h0, 4'h0, 0, 1, 4'h6, 4'h0, 0);

    // Asynchronous reset mid-burst, right after a port 2 read beat.
    #2;
    reset = 1'b1;
    #1;
    check("async_gnt2", bus.gnt2, 1'b0);
    check("async_rvalid2", bus.rvalid2, 1'b0);
    check("async_mem_sel", bus.mem_sel, 1'b0);
    drive_idle();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) step(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
    step(1, 4'h8, 4'h0, 0, 1, 4'h9, 4'h0, 0);
    step(1, 4'h8, 4'h0, 0, 1, 4'h9, 4'h0, 0);
    check("post_rst_first_gnt1", bus.gnt1, 1'b1);
    repeat (2) step(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);

    // Random traffic against the model.
    do_reset();
    repeat (80) step(1'($urandom_range(0, 1)) | 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)) | 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                     1'($urandom_range(0, 1)));
    repeat (3) step(0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0);
    check("rdq_drained", rdq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
